interconnect_link_merge_buffer: RTL and testbench
=================================================

Name: interconnect_link_merge_buffer

Overview:
- Parametrised successor to the single-link interconnect combiner.
- Merges NUM_PLANES physical-plane links of an interconnect bundle onto one local link for peripherals attached to the mesh.
- Adds selectable fixed-priority or round-robin arbitration, a DEPTH-entry elastic buffer, source-plane reporting, occupancy reporting, and a sticky multi-request error flag (software contract: one plane active at a time).

Parameters:
- NUM_PLANES, 4, number of physical planes merged (>=1).
- TAG_WIDTH, 3, packet tag width.
- WORD_WIDTH, 32, packet data width.
- DEPTH, 4, buffer entries (>=1; any integer, not necessarily a power of two).
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_reqs  in  NUM_PLANES  per-plane request.
- in_acks  out  NUM_PLANES  per-plane acknowledge.
- in_tags  in  NUM_PLANES*TAG_WIDTH  per-plane tag; plane i occupies bits [i*TAG_WIDTH +: TAG_WIDTH].
- in_data  in  NUM_PLANES*WORD_WIDTH  per-plane data; same packing rule.
- out_req  out  1  buffered packet available.
- out_ack  in  1  downstream accepts head.
- out_tag  out  TAG_WIDTH  head tag.
- out_data  out  WORD_WIDTH  head data.
- out_src  out  max(1,$clog2(NUM_PLANES))  plane index the head arrived on.
- occupancy  out  $clog2(DEPTH+1)  entries held.
- error_clear  in  1  synchronous clear of multi_req_error.
- multi_req_error  out  1  sticky: more than one in_reqs bit seen high.

Behaviour:
- Handshake: a transfer occurs on any edge where req and ack are both high. Same rule on the input and output sides.
- Grant:
  - Computed combinationally from in_reqs when occupancy < DEPTH.
  - Exactly one in_acks bit high (the granted plane); all others 0.
  - All in_acks are 0 when there is no request or the buffer is full.
- Full/empty coupling: in_acks must not depend on out_ack. When full, push is blocked even if a pop occurs in the same cycle. No combinational path from out_ack to in_acks.
- Fixed mode: grant goes to the lowest-index requesting plane.
- Round-robin mode:
  - Pointer last_grant searches from (last_grant+1) mod NUM_PLANES upward, with wrap.
  - Pointer updates to the granted index only on an accepted transfer.
  - Reset value of last_grant is NUM_PLANES-1, so plane 0 has first priority.
- Buffer:
  - Circular FIFO of {tag, data, src}.
  - Push writes the tail; pop advances the head. Pointers wrap at DEPTH.
  - Simultaneous push and pop with 0 < occupancy < DEPTH leaves occupancy unchanged.
- Output timing:
  - out_req = (occupancy != 0).
  - out_tag, out_data and out_src show the head entry.
  - A packet pushed at edge t is visible on out_* after edge t; minimum latency is one cycle.
  - Empty-buffer pass-through is forbidden.
- Empty output values: when empty, out_tag, out_data and out_src are all zeros. Stale entries are never exposed.
- Error flag:
  - multi_req_error sets at the edge following any cycle with popcount(in_reqs) > 1, regardless of grant or full.
  - error_clear clears it; if set and clear happen in the same cycle, set wins.
- Reset, asserted asynchronously at any time including mid-transfer:
  - Immediately: out_req=0, out_tag=0, out_data=0, out_src=0, occupancy=0, multi_req_error=0, in_acks=0.
  - Pointers are zeroed and last_grant is set to NUM_PLANES-1.
  - Buffered packets are discarded.
  - in_acks stays 0 while reset is high.
- NUM_PLANES=1 degenerates to a plain DEPTH-entry buffer with out_src tied to 0.

Test Plan:
- Single plane: plane 2 req with tag=3, data=0xDEADBEEF; out_ack=1 -> in_acks=4'b0100 in that cycle; next cycle out_req=1, out_tag=3, out_data=0xDEADBEEF, out_src=2, occupancy=1; following cycle occupancy=0 and out_* are zeros.
- Round-robin: ARB_MODE=1, planes 0,1,3 request continuously, out_ack=1 -> accepted sources 0,1,3,0,1,3 on out_src; multi_req_error=1 from cycle 1 onward; error_clear pulse with requests still active -> flag stays 1.
- Fixed priority: ARB_MODE=0, planes 1 and 2 request continuously -> in_acks=4'b0010 every cycle; plane 2 is never acked.
- Fill and drain: DEPTH=4, out_ack=0, plane 1 offers data 1..6 -> four accepted, occupancy=4, in_acks=0 afterwards; then out_ack=1 -> outputs 1,2,3,4 in order, followed by 5 and 6.
- Full with simultaneous pop: occupancy=4, out_ack=1, plane 0 requesting -> no ack that cycle, occupancy=3; next cycle ack, occupancy stays 3.
- Reset mid-operation: occupancy=3, assert reset between edges -> all outputs 0 immediately; after release with planes 0 and 3 requesting in round-robin mode, the first grant is plane 0 and nothing from before reset appears on out_*.

Source files
------------

// File: rtl/interconnect_link_merge_buffer.sv
// Merges NUM_PLANES request/ack links into one buffered local link with
// fixed-priority or round-robin arbitration and a sticky multi-request flag.
module interconnect_link_merge_buffer #(
    parameter int NUM_PLANES = 4,
    parameter int TAG_WIDTH  = 3,
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ARB_MODE   = 1
) (
    input  logic                                                  clock,
    input  logic                                                  reset,
    input  logic [NUM_PLANES-1:0]                                 in_reqs,
    output logic [NUM_PLANES-1:0]                                 in_acks,
    input  logic [NUM_PLANES*TAG_WIDTH-1:0]                       in_tags,
    input  logic [NUM_PLANES*WORD_WIDTH-1:0]                      in_data,
    output logic                                                  out_req,
    input  logic                                                  out_ack,
    output logic [TAG_WIDTH-1:0]                                  out_tag,
    output logic [WORD_WIDTH-1:0]                                 out_data,
    output logic [((NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1)-1:0] out_src,
    output logic [$clog2(DEPTH+1)-1:0]                            occupancy,
    input  logic                                                  error_clear,
    output logic                                                  multi_req_error
);

    localparam int SRC_W = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [TAG_WIDTH-1:0]  tag_mem  [DEPTH];
    logic [WORD_WIDTH-1:0] data_mem [DEPTH];
    logic [SRC_W-1:0]      src_mem  [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [SRC_W-1:0] last_q, last_d;
    logic             err_q, err_d;

    logic             full;
    logic             gnt_vld;
    logic [SRC_W-1:0] gnt_idx;
    logic             push;
    logic             pop;
    logic             multi;
    int               idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == OCC_W'(DEPTH));
    assign multi = ($countones(in_reqs) > 1);

    // Descending scans so the highest-priority candidate is assigned last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (ARB_MODE == 0) begin
            for (int i = NUM_PLANES - 1; i >= 0; i--) begin
                if (in_reqs[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SRC_W'(i);
                end
            end
        end else begin
            for (int k = NUM_PLANES; k >= 1; k--) begin
                idx = (int'(last_q) + k) % NUM_PLANES;
                if (in_reqs[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SRC_W'(idx);
                end
            end
        end
    end

    // Acks depend only on requests and stored occupancy, never on out_ack.
    assign push    = gnt_vld & ~full & ~reset;
    assign in_acks = push ? (NUM_PLANES'(1) << gnt_idx) : '0;
    assign pop     = out_req & out_ack;

    assign out_req   = (count_q != '0);
    assign occupancy = count_q;
    assign out_tag   = out_req ? tag_mem[head_q]  : '0;
    assign out_data  = out_req ? data_mem[head_q] : '0;
    assign out_src   = out_req ? src_mem[head_q]  : '0;
    assign multi_req_error = err_q;

    always_comb begin
        head_d  = pop  ? ptr_inc(head_q) : head_q;
        tail_d  = push ? ptr_inc(tail_q) : tail_q;
        last_d  = push ? gnt_idx : last_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        err_d = err_q;
        if (multi) begin
            err_d = 1'b1;
        end else if (error_clear) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            last_q  <= SRC_W'(NUM_PLANES - 1);
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Storage needs no reset: entries are only visible below count_q.
    always_ff @(posedge clock) begin
        if (push) begin
            tag_mem[tail_q]  <= in_tags[int'(gnt_idx)*TAG_WIDTH +: TAG_WIDTH];
            data_mem[tail_q] <= in_data[int'(gnt_idx)*WORD_WIDTH +: WORD_WIDTH];
            src_mem[tail_q]  <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_interconnect_link_merge_buffer.sv
// Bench for interconnect_link_merge_buffer: vector table, hand sequences,
// and a negedge reference model with a packet scoreboard.
module tb_interconnect_link_merge_buffer;

    localparam int NP    = 4;
    localparam int TW    = 3;
    localparam int WW    = 32;
    localparam int DEPTH = 4;

    logic              clock;
    logic              reset;
    logic [NP-1:0]     reqs;
    logic [NP-1:0]     acks;
    logic [NP-1:0][TW-1:0] tags;
    logic [NP-1:0][WW-1:0] data;
    logic              oreq;
    logic              oack;
    logic [TW-1:0]     otag;
    logic [WW-1:0]     odata;
    logic [1:0]        osrc;
    logic [2:0]        occ;
    logic              eclr;
    logic              err;

    logic [NP-1:0]     reqs_fp;
    logic [NP-1:0]     acks_fp;
    logic              oreq_fp;
    logic [TW-1:0]     otag_fp;
    logic [WW-1:0]     odata_fp;
    logic [1:0]        osrc_fp;
    logic [2:0]        occ_fp;
    logic              err_fp;

    int tests = 0;
    int fails = 0;

    interconnect_link_merge_buffer #(
        .NUM_PLANES(NP), .TAG_WIDTH(TW), .WORD_WIDTH(WW),
        .DEPTH(DEPTH), .ARB_MODE(1)
    ) dut (
        .clock(clock), .reset(reset),
        .in_reqs(reqs), .in_acks(acks),
        .in_tags(tags), .in_data(data),
        .out_req(oreq), .out_ack(oack),
        .out_tag(otag), .out_data(odata), .out_src(osrc),
        .occupancy(occ), .error_clear(eclr),
        .multi_req_error(err)
    );

    interconnect_link_merge_buffer #(
        .NUM_PLANES(NP), .TAG_WIDTH(TW), .WORD_WIDTH(WW),
        .DEPTH(DEPTH), .ARB_MODE(0)
    ) dut_fp (
        .clock(clock), .reset(reset),
        .in_reqs(reqs_fp), .in_acks(acks_fp),
        .in_tags(tags), .in_data(data),
        .out_req(oreq_fp), .out_ack(1'b1),
        .out_tag(otag_fp), .out_data(odata_fp), .out_src(osrc_fp),
        .occupancy(occ_fp), .error_clear(1'b0),
        .multi_req_error(err_fp)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: packets expected on out_* in arrival order.
    typedef struct packed {
        logic [TW-1:0] tag;
        logic [WW-1:0] data;
        logic [1:0]    src;
    } pkt_t;

    pkt_t mq[$];
    int   m_last = NP - 1;
    bit   m_err  = 1'b0;

    always @(negedge clock) begin
        logic [NP-1:0] eacks;
        int g;
        if (reset) begin
            mq.delete();
            m_last = NP - 1;
            m_err  = 1'b0;
            chk("rst_acks", acks, 0);
            chk("rst_oreq", oreq, 0);
            chk("rst_occ", occ, 0);
            chk("rst_out", {otag, odata, osrc}, 0);
            chk("rst_err", err, 0);
        end else begin
            g = -1;
            eacks = '0;
            if (mq.size() < DEPTH) begin
                for (int k = 1; k <= NP; k++) begin
                    if (g < 0 && reqs[(m_last + k) % NP]) g = (m_last + k) % NP;
                end
            end
            if (g >= 0) eacks[g] = 1'b1;
            chk("sb_acks", acks, eacks);
            chk("sb_occ", occ, mq.size());
            chk("sb_oreq", oreq, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("sb_pkt", {otag, odata, osrc}, mq[0]);
            end else begin
                chk("sb_empty", {otag, odata, osrc}, 0);
            end
            chk("sb_err", err, m_err);
            if (mq.size() != 0 && oack) void'(mq.pop_front());
            if (g >= 0) begin
                mq.push_back({tags[g], data[g], 2'(g)});
                m_last = g;
            end
            if ($countones(reqs) > 1) m_err = 1'b1;
            else if (eclr) m_err = 1'b0;
        end
    end

    typedef struct {
        logic [NP-1:0] reqs;
        logic          oack;
        logic          eclr;
        logic [NP-1:0] acks;
        logic          err;
        logic [1:0]    src;
        logic [2:0]    occ;
    } vec_t;

    vec_t vt[9];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #4 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        reqs = '1; reqs_fp = '0; oack = 1'b0; eclr = 1'b0;
        for (int i = 0; i < NP; i++) begin
            tags[i] = TW'(i + 1);
            data[i] = 32'h100 + i;
        end

        vt[0] = '{4'b1011, 1, 0, 4'b0001, 0, 2'd0, 3'd0};
        vt[1] = '{4'b1011, 1, 0, 4'b0010, 1, 2'd0, 3'd1};
        vt[2] = '{4'b1011, 1, 0, 4'b1000, 1, 2'd1, 3'd1};
        vt[3] = '{4'b1011, 1, 0, 4'b0001, 1, 2'd3, 3'd1};
        vt[4] = '{4'b1011, 1, 0, 4'b0010, 1, 2'd0, 3'd1};
        vt[5] = '{4'b1011, 1, 0, 4'b1000, 1, 2'd1, 3'd1};
        vt[6] = '{4'b1011, 1, 1, 4'b0001, 1, 2'd3, 3'd1};
        vt[7] = '{4'b0000, 1, 1, 4'b0000, 1, 2'd0, 3'd1};
        vt[8] = '{4'b0000, 1, 0, 4'b0000, 0, 2'd0, 3'd0};

        tick();
        tick();
        chk("reset_acks_held", acks, 0);
        chk("reset_oreq", oreq, 0);
        reqs = '0;
        @(negedge clock);
        reset = 1'b0;
        tick();

        // Single plane 2 packet, one-cycle latency then empty zeros.
        reqs = 4'b0100; oack = 1'b1;
        tags[2] = 3'd3; data[2] = 32'hDEADBEEF;
        #2 chk("single_acks", acks, 4'b0100);
        tick();
        reqs = '0;
        #2 chk("single_pkt", {oreq, otag, odata, osrc, occ},
               {1'b1, 3'd3, 32'hDEADBEEF, 2'd2, 3'd1});
        tick();
        #2 chk("single_drained", {oreq, otag, odata, osrc, occ}, 0);
        tags[2] = 3'd3; data[2] = 32'h102;

        pulse_reset();
        tick();

        // Round-robin over planes 0,1,3 with error flag behaviour.
        foreach (vt[i]) begin
            reqs = vt[i].reqs; oack = vt[i].oack; eclr = vt[i].eclr;
            #2;
            chk($sformatf("rr_acks[%0d]", i), acks, vt[i].acks);
            chk($sformatf("rr_err[%0d]", i), err, vt[i].err);
            chk($sformatf("rr_src[%0d]", i), osrc, vt[i].src);
            chk($sformatf("rr_occ[%0d]", i), occ, vt[i].occ);
            tick();
        end
        eclr = 1'b0;

        // Fill to DEPTH with out_ack low, then drain with a full-cycle pop.
        oack = 1'b0; reqs = 4'b0010;
        for (int v = 1; v <= 4; v++) begin
            data[1] = WW'(v);
            tick();
        end
        data[1] = 32'd5;
        #2 chk("fill_full_acks", acks, 0);
        chk("fill_occ", occ, 4);
        tick();
        chk("fill_hold_occ", occ, 4);
        oack = 1'b1;
        #2 chk("full_pop_noack", acks, 0);
        chk("full_pop_head", odata, 1);
        tick();
        #2 chk("after_pop_ack", acks, 4'b0010);
        chk("after_pop_occ", occ, 3);
        tick();
        data[1] = 32'd6;
        #2 chk("steady_occ", occ, 3);
        chk("steady_head", odata, 3);
        tick();
        reqs = '0;
        for (int i = 0; i < 4; i++) tick();
        chk("drain_empty", occ, 0);

        // Fixed priority instance: plane 1 always beats plane 2.
        reqs_fp = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            #2 chk($sformatf("fp_acks[%0d]", i), acks_fp, 4'b0010);
            tick();
        end
        reqs_fp = '0;

        // Reset mid-operation with three packets buffered.
        oack = 1'b0; reqs = 4'b0100;
        for (int i = 0; i < 3; i++) tick();
        reqs = '0;
        #1 chk("pre_reset_occ", occ, 3);
        reset = 1'b1;
        #1 chk("async_reset_out", {oreq, otag, odata, osrc, occ, err, acks}, 0);
        @(negedge clock);
        #1 reset = 1'b0;
        tick();
        reqs = 4'b1001; oack = 1'b1;
        #2 chk("post_reset_grant", acks, 4'b0001);
        chk("post_reset_empty", {oreq, otag, odata, osrc}, 0);
        tick();
        reqs = '0;
        #2 chk("post_reset_src", {oreq, osrc, odata}, {1'b1, 2'd0, 32'h100});
        for (int i = 0; i < 4; i++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
